// File: rtl/pipe_ctrl.sv
// pipe_ctrl: five-stage pipeline stall/flush sequencer with multi-cycle EX countdown (optional perf counters under PIPE_CTRL_PERF_EN)
module pipe_ctrl #(
  parameter int STALL_W = 6,
  parameter int CNT_W   = 6,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               stallreq_from_ex,
  input  logic               mc_start,
  input  logic [CNT_W-1:0]   mc_len,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [31:0]        new_pc_o,
  output logic               mc_busy_o,
  output logic               mc_done_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]  stall_cycles_o,
  output logic [PERF_W-1:0]  flush_count_o
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [STALL_W-1:0] ID_STALL = STALL_W'(7);
  localparam logic [STALL_W-1:0] EX_STALL = STALL_W'(15);
  state_t state, state_n;
  logic [CNT_W-1:0] count, count_n;
  // state and countdown register; reset or flush abandons any op in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_n;
      count <= count_n;
    end
  end
  // next state: a length of 0 or 1 goes straight to DONE, longer ops count down in BUSY
  always_comb begin
    state_n = state;
    count_n = count;
    if (flush_req) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        IDLE: if (mc_start) begin
          state_n = (mc_len > CNT_W'(1)) ? BUSY : DONE;
          count_n = (mc_len > CNT_W'(1)) ? mc_len - CNT_W'(1) : '0;
        end
        BUSY: begin
          state_n = (count == CNT_W'(1)) ? DONE : BUSY;
          count_n = count - CNT_W'(1);
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // outputs: flush beats everything, BUSY forces EX stall, mc_start only counts in IDLE
  always_comb begin
    stall_o  = '0;
    flush_o  = 1'b0;
    new_pc_o = '0;
    if (rst) begin
      if (flush_req) begin
        flush_o  = 1'b1;
        new_pc_o = flush_pc;
      end else if (state == BUSY || stallreq_from_ex || (mc_start && state == IDLE)) begin
        stall_o = EX_STALL;
      end else if (stallreq_from_id) begin
        stall_o = ID_STALL;
      end
    end
  end
  assign mc_busy_o = (state == BUSY);
  assign mc_done_o = (state == DONE);
`ifdef PIPE_CTRL_PERF_EN
  // saturating counts of stalled cycles and flush cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (stall_o != '0 && !(&stall_cycles_o)) stall_cycles_o <= stall_cycles_o + PERF_W'(1);
      if (flush_o && !(&flush_count_o)) flush_count_o <= flush_count_o + PERF_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id, stallreq_from_ex, mc_start, flush_req;
  logic [5:0]  mc_len;
  logic [31:0] flush_pc;
  logic [5:0]  stall_o;
  logic        flush_o, mc_busy_o, mc_done_o;
  logic [31:0] new_pc_o;
  int tests = 0;
  int fails = 0;
  int n;
  int dones;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles_o, flush_count_o;
`endif

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
    .mc_start(mc_start), .mc_len(mc_len),
    .flush_req(flush_req), .flush_pc(flush_pc),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
    .mc_busy_o(mc_busy_o), .mc_done_o(mc_done_o)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles_o(stall_cycles_o), .flush_count_o(flush_count_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stallreq_from_id = 1'b1; stallreq_from_ex = 1'b1; mc_start = 1'b1;
    mc_len = 6'd5; flush_req = 1'b1; flush_pc = 32'hdead_beef;
    #3;
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_newpc", new_pc_o, 32'h0);
    tick; tick;
    chk("rst_busy", 32'(mc_busy_o), 32'h0);
    chk("rst_done", 32'(mc_done_o), 32'h0);
    stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0; mc_start = 1'b0;
    mc_len = 6'd0; flush_req = 1'b0; flush_pc = 32'h0;
    @(negedge clk); rst = 1'b1;
    tick;
    chk("idle_stall", 32'(stall_o), 32'h0);
    chk("idle_busy", 32'(mc_busy_o), 32'h0);
    // load-use then combined with EX hold
    stallreq_from_id = 1'b1; #1;
    chk("id_stall", 32'(stall_o), 32'h07);
    stallreq_from_ex = 1'b1; #1;
    chk("id_ex_stall", 32'(stall_o), 32'h0f);
    tick;
    stallreq_from_id = 1'b0; stallreq_from_ex = 1'b0; #1;
    chk("id_released", 32'(stall_o), 32'h0);
    // multi-cycle op, length 5
    mc_start = 1'b1; mc_len = 6'd5; #1;
    chk("mc5_T_stall", 32'(stall_o), 32'h0f);
    chk("mc5_T_busy", 32'(mc_busy_o), 32'h0);
    tick;
    mc_start = 1'b0; mc_len = 6'd63; #1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("mc5_T%0d_stall", i), 32'(stall_o), 32'h0f);
      chk($sformatf("mc5_T%0d_busy", i), 32'(mc_busy_o), 32'h1);
      chk($sformatf("mc5_T%0d_done", i), 32'(mc_done_o), 32'h0);
      tick;
    end
    mc_start = 1'b1; #1;
    chk("mc5_done", 32'(mc_done_o), 32'h1);
    chk("mc5_done_busy", 32'(mc_busy_o), 32'h0);
    chk("mc5_done_ignores_start", 32'(stall_o), 32'h0);
    tick;
    mc_start = 1'b0; #1;
    chk("mc5_after_done", 32'(mc_done_o), 32'h0);
    chk("mc5_after_busy", 32'(mc_busy_o), 32'h0);
    chk("mc5_after_stall", 32'(stall_o), 32'h0);
    // length 0 behaves as length 1
    mc_start = 1'b1; mc_len = 6'd0; #1;
    chk("mc0_stall", 32'(stall_o), 32'h0f);
    tick;
    mc_start = 1'b0; #1;
    chk("mc0_done", 32'(mc_done_o), 32'h1);
    chk("mc0_busy", 32'(mc_busy_o), 32'h0);
    chk("mc0_stall_after", 32'(stall_o), 32'h0);
    tick;
    // back-to-back start right after DONE, length 2
    mc_start = 1'b1; mc_len = 6'd2; #1;
    chk("mc2_stall", 32'(stall_o), 32'h0f);
    tick;
    mc_start = 1'b0; #1;
    chk("mc2_busy", 32'(mc_busy_o), 32'h1);
    chk("mc2_busy_stall", 32'(stall_o), 32'h0f);
    tick;
    chk("mc2_done", 32'(mc_done_o), 32'h1);
    tick;
    // maximum length
    mc_start = 1'b1; mc_len = 6'd63; #1;
    n = 0;
    while (stall_o !== 6'd0 && n < 100) begin
      n++;
      tick;
      mc_start = 1'b0; #1;
    end
    chk("mc63_cycles", 32'(n), 32'd63);
    chk("mc63_done", 32'(mc_done_o), 32'h1);
    tick;
    // flush aborts a length-10 op at T+3
    mc_start = 1'b1; mc_len = 6'd10; #1;
    tick;
    mc_start = 1'b0; tick; tick;
    flush_req = 1'b1; flush_pc = 32'h0000_0100; mc_start = 1'b1; stallreq_from_ex = 1'b1; #1;
    chk("flush_o", 32'(flush_o), 32'h1);
    chk("flush_pc", new_pc_o, 32'h100);
    chk("flush_stall", 32'(stall_o), 32'h0);
    tick;
    flush_req = 1'b0; mc_start = 1'b0; stallreq_from_ex = 1'b0; #1;
    chk("flush_idle_busy", 32'(mc_busy_o), 32'h0);
    chk("flush_idle_flush", 32'(flush_o), 32'h0);
    chk("flush_idle_pc", new_pc_o, 32'h0);
    chk("flush_idle_stall", 32'(stall_o), 32'h0);
    dones = 0;
    repeat (12) begin
      if (mc_done_o) dones++;
      tick;
    end
    chk("flush_no_done", 32'(dones), 32'h0);
    // asynchronous reset in the middle of an op
    mc_start = 1'b1; mc_len = 6'd5; #1;
    tick;
    mc_start = 1'b0; #1;
    chk("midrst_busy_before", 32'(mc_busy_o), 32'h1);
    #2 rst = 1'b0; #1;
    chk("midrst_busy", 32'(mc_busy_o), 32'h0);
    chk("midrst_stall", 32'(stall_o), 32'h0);
    @(negedge clk); rst = 1'b1;
    dones = 0;
    repeat (8) begin
      tick;
      if (mc_done_o || mc_busy_o) dones++;
    end
    chk("midrst_no_resume", 32'(dones), 32'h0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_rst_stall", stall_cycles_o, 32'h0);
    chk("perf_rst_flush", flush_count_o, 32'h0);
    mc_start = 1'b1; mc_len = 6'd5; #1;
    tick;
    mc_start = 1'b0;
    repeat (6) tick;
    flush_req = 1'b1; flush_pc = 32'h200;
    tick;
    flush_req = 1'b0; #1;
    chk("perf_stall_cycles", stall_cycles_o, 32'd5);
    chk("perf_flush_count", flush_count_o, 32'd1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencing controller for the five-stage core (pc_reg, if_id, id_ex, ex_mem, mem_wb). It merges stall requests from ID (load-use) and EX (single-cycle hold), and runs a countdown state machine for multi-cycle EX operations such as divide and multiply-accumulate. It also arbitrates pipeline flushes, which redirect the PC.
- Outputs: a per-stage stall vector, a flush strobe with redirect PC, and a multi-cycle completion pulse.

Parameters:
STALL_W, 6, stall vector width. bit0=pc_reg, 1=if_id, 2=id_ex, 3=ex_mem, 4=mem_wb, 5=regfile write hold.
CNT_W, 6, multi-cycle length / countdown width.
PERF_W, 32, width of the performance counters (optional feature).

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low
stallreq_from_id  input  1  ID load-use hazard; hold PC, IF/ID and ID
stallreq_from_ex  input  1  EX single-cycle hold request
mc_start  input  1  EX begins a multi-cycle op; sampled only in IDLE
mc_len  input  CNT_W  number of stall cycles for the op; 0 is treated as 1
flush_req  input  1  exception/redirect request
flush_pc  input  32  redirect target
stall_o  output  STALL_W  per-stage hold vector (combinational)
flush_o  output  1  clear all pipeline registers and load new_pc_o (combinational)
new_pc_o  output  32  redirect PC; valid when flush_o=1, else 0
mc_busy_o  output  1  registered; 1 while state=BUSY
mc_done_o  output  1  registered; one-cycle pulse, EX captures its result

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, mc_busy_o=0, mc_done_o=0, perf counters=0.
- During reset, combinational outputs also read 0: stall_o=0, flush_o=0, new_pc_o=0.
- States: IDLE, BUSY, DONE.
- Stall encodings: ID-stall=6'b000111; EX-stall=6'b001111; none=0.
- Priority, highest first: flush_req > BUSY > stallreq_from_ex / mc_start > stallreq_from_id.
- flush_req=1 in any state:
  - flush_o=1, new_pc_o=flush_pc, stall_o=0 in the same cycle.
  - Next state=IDLE, count=0.
  - mc_done_o is never pulsed for an aborted op.
  - A mc_start in that same cycle is ignored.
- IDLE:
  - stall_o=EX-stall if stallreq_from_ex or mc_start; else ID-stall if stallreq_from_id; else 0.
  - On mc_start: let L = max(mc_len,1).
  - L=1: next state=DONE.
  - L>1: next state=BUSY, count=L-1.
- BUSY:
  - stall_o=EX-stall regardless of other requests; mc_busy_o=1.
  - count decrements each cycle; when count==1 the next state is DONE.
- DONE:
  - Lasts exactly one cycle; mc_done_o=1 (registered, asserted in this cycle); mc_busy_o=0.
  - stall_o follows the IDLE rules, but mc_start is ignored.
  - Next state=IDLE.
- Latency: mc_start at cycle T gives exactly L stalled cycles (T..T+L-1) and mc_done_o at T+L. Back-to-back ops are possible from T+L+1.
- Width rules:
  - count never wraps.
  - mc_len=63 gives 63 stall cycles.
  - mc_len is not resampled while BUSY.
- Reset mid-operation aborts immediately to the reset values. No pending mc_done_o survives reset.

Optional Feature:
Macro PIPE_CTRL_PERF_EN.
- Defined:
  - Adds output ports stall_cycles_o [PERF_W-1:0] and flush_count_o [PERF_W-1:0].
  - stall_cycles_o increments on every cycle with stall_o!=0.
  - flush_count_o increments on every cycle with flush_o=1.
  - Both saturate at all-ones and reset to 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 with all inputs active -> every output 0. Release rst -> state IDLE, stall_o=0.
- Load-use: stallreq_from_id=1 for 1 cycle -> stall_o=6'b000111 for that cycle only. Same cycle with stallreq_from_ex=1 -> 6'b001111.
- Multi-cycle op: mc_start=1, mc_len=5 at T -> stall_o=6'b001111 at T..T+4, mc_busy_o=1 at T+1..T+4, mc_done_o=1 at T+5 only.
- Length edge cases:
  - mc_len=0 -> 1 stall cycle, mc_done_o at T+1.
  - mc_len=63 -> 63 stall cycles.
- Flush abort: mc_len=10 started, then flush_req=1, flush_pc=32'h0000_0100 at T+3 -> flush_o=1, new_pc_o=32'h100, stall_o=0 at T+3. IDLE at T+4; no mc_done_o ever.
- Perf, with PIPE_CTRL_PERF_EN defined: run the mc_len=5 op plus one flush -> stall_cycles_o=5, flush_count_o=1.
